serial_adder: RTL

Bit-serial, parametrised successor to the combinational `full_adder`. The block accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It adds them LSB-first, one bit per clock, by instantiating a single `full_adder` with a registered carry, then presents the WIDTH-bit sum and carry-out through a second valid/ready handshake. It trades latency for area in datapaths where a WIDTH-bit ripple adder is too large.

---
 rtl/adder_pkg.sv | 5 +
 rtl/full_adder.sv | 11 +
 rtl/serial_adder.sv | 82 ++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and width limit for the serial adder
package adder_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int MAX_WIDTH = 64;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder, the single arithmetic cell of the serial adder
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic carry,
    output logic sum
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial WIDTH-bit adder with valid/ready on both sides
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic [WIDTH:0]   s_cat;
    logic [CW-1:0]    cnt;
    logic             carry, fa_carry, fa_sum, last;

    full_adder u_fa (
        .a(a_sh[0]),
        .b(b_sh[0]),
        .c(carry),
        .carry(fa_carry),
        .sum(fa_sum)
    );

    // new sum bit enters at the MSB; the concat keeps this legal for WIDTH=1
    assign s_cat     = {fa_sum, s_sh};
    assign last      = cnt == CW'(WIDTH - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign sum       = s_sh;
    assign cout      = carry;

    // next state: accept in IDLE, count WIDTH edges in BUSY, wait for consumer in DONE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? BUSY : IDLE;
            BUSY:    state_nx = last ? DONE : BUSY;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // datapath: load operands on accept, shift one bit per BUSY edge, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == IDLE && in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            s_sh  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == BUSY) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            s_sh  <= s_cat[WIDTH:1];
            carry <= fa_carry;
            cnt   <= cnt + 1'b1;
        end
    end
endmodule
